gf_mult_inv_serial: RTL and testbench

//   Bit-serial multiplier/inverter over GF(2^M), polynomial basis, with the modulus set by parameter.

---
 rtl/gf_pkg.sv | 22 ++
 rtl/gf_serial_mul_core.sv | 61 ++++++
 rtl/gf_mult_inv_serial.sv | 139 +++++++++++++
 tb/tb_gf_mult_inv_serial.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^M) serial multiplier/inverter.
//   - operation encoding on in_op
//   - FSM state type of the top
//   - common field polynomials
package gf_pkg;

  localparam logic GF_OP_MUL = 1'b0;
  localparam logic GF_OP_INV = 1'b1;

  // x^4 + x + 1 and the AES polynomial x^8 + x^4 + x^3 + x + 1
  localparam logic [4:0] GF4_POLY = 5'h13;
  localparam logic [8:0] GF8_POLY = 9'h11B;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StInvSq,
    StInvMl,
    StDone
  } gf_state_e;

endpackage

// File: rtl/gf_serial_mul_core.sv
// MSB-first bit-serial GF(2^M) multiplier, one bit of b per clock.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      begin a multiply (ignored while busy); the first step is taken on this edge
//   a, b       operands; must be held stable until done
//   busy       a multiply is in progress beyond its first step
//   done       the current cycle performs the last step; p is the finished product
//   p          value acc takes at the next edge (the product when done is high)
module gf_serial_mul_core #(
  parameter int unsigned M    = 4,
  parameter logic [M:0]  POLY = 5'h13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] p
);

  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

  logic [M-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] j;
  logic [M-1:0]  base;
  logic [M:0]    sh;
  logic          step;

  always_comb begin
    step = start | busy;
    j    = busy ? cnt : CW'(M - 1);
    // A fresh multiply starts from a cleared accumulator.
    base = busy ? acc : '0;
    sh   = {base, 1'b0};
    if (sh[M]) begin
      sh = sh ^ POLY;
    end
    p    = sh[M-1:0] ^ (b[j] ? a : '0);
    done = step && (j == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
    end else if (step) begin
      acc <= p;
      if (done) begin
        busy <= 1'b0;
      end else begin
        busy <= 1'b1;
        cnt  <= j - CW'(1);
      end
    end
  end

endmodule

// File: rtl/gf_mult_inv_serial.sv
// GF(2^M) multiplier / inverter with valid/ready handshakes.
// MUL takes M cycles; INV computes a^(2^M-2) as M-1 rounds of (s <= s*s, r <= r*s).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              request handshake (ready only when idle)
//   in_op, in_a, in_b              operation (0 = MUL, 1 = INV) and operands
//   out_valid/out_ready            result handshake, result held until accepted
//   out_result, out_err            product/inverse; err flags INV of zero
module gf_mult_inv_serial
  import gf_pkg::*;
#(
  parameter int unsigned M    = 4,
  parameter logic [M:0]  POLY = GF4_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_result,
  output logic         out_err
);

  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
  localparam logic [RW-1:0] ROUND_LAST = RW'(M - 2);

  gf_state_e     state;
  logic [M-1:0]  a_reg, b_reg, r, s;
  logic [RW-1:0] round;

  logic [M-1:0] core_a, core_b, core_p;
  logic         core_start, core_busy, core_done;

  always_comb begin
    core_a = a_reg;
    core_b = b_reg;
    case (state)
      StInvSq: begin
        core_a = s;
        core_b = s;
      end
      StInvMl: begin
        core_a = r;
        core_b = s;
      end
      default: ;
    endcase
    // Each arithmetic state kicks off exactly one multiply in its first cycle.
    core_start = ((state == StMul) || (state == StInvSq) || (state == StInvMl)) && !core_busy;
  end

  gf_serial_mul_core #(
    .M    (M),
    .POLY (POLY)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .a     (core_a),
    .b     (core_b),
    .busy  (core_busy),
    .done  (core_done),
    .p     (core_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      r          <= '0;
      s          <= '0;
      round      <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            round    <= '0;
            in_ready <= 1'b0;
            if (in_op == GF_OP_INV) begin
              r     <= {{(M - 1){1'b0}}, 1'b1};
              s     <= in_a;
              state <= StInvSq;
            end else begin
              state <= StMul;
            end
          end
        end
        StMul: begin
          if (core_done) begin
            out_result <= core_p;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= StDone;
          end
        end
        StInvSq: begin
          if (core_done) begin
            s     <= core_p;
            state <= StInvMl;
          end
        end
        StInvMl: begin
          if (core_done) begin
            r <= core_p;
            if (round == ROUND_LAST) begin
              out_result <= core_p;
              out_err    <= (a_reg == '0);
              out_valid  <= 1'b1;
              state      <= StDone;
            end else begin
              round <= round + 1'b1;
              state <= StInvSq;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mult_inv_serial.sv
// Bench for gf_mult_inv_serial: an M=4 and an M=8 (AES polynomial) instance, checked against a
// long-division reference multiplier and a brute-force inverse search.
module tb_gf_mult_inv_serial;
  import gf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v4 = 0, op4 = 0, ordy4 = 0, rdy4, ov4, err4;
  logic [3:0] a4 = 0, b4 = 0, res4;
  logic       v8 = 0, op8 = 0, ordy8 = 0, rdy8, ov8, err8;
  logic [7:0] a8 = 0, b8 = 0, res8;

  gf_mult_inv_serial #(.M(4), .POLY(GF4_POLY)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_op(op4), .in_a(a4), .in_b(b4),
    .out_valid(ov4), .out_ready(ordy4), .out_result(res4), .out_err(err4)
  );

  gf_mult_inv_serial #(.M(8), .POLY(GF8_POLY)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_op(op8), .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(ordy8), .out_result(res8), .out_err(err8)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: full carry-less product, then polynomial long division.
  function automatic int unsigned ref_mul(int unsigned a, int unsigned b, int unsigned m,
                                          int unsigned poly);
    int unsigned prod = 0;
    for (int i = 0; i < int'(m); i++) if ((b >> i) & 1) prod ^= (a << i);
    for (int i = 2 * int'(m) - 2; i >= int'(m); i--) if ((prod >> i) & 1) prod ^= (poly << (i - m));
    return prod;
  endfunction

  function automatic int unsigned ref_inv(int unsigned a, int unsigned m, int unsigned poly);
    if (a == 0) return 0;
    for (int unsigned x = 1; x < (1 << m); x++) if (ref_mul(a, x, m, poly) == 1) return x;
    return 0;
  endfunction

  // Observation mux over the two instances.
  bit         sel8 = 0;
  logic       cur_ov, cur_rdy, cur_err;
  logic [7:0] cur_res;
  always_comb begin
    cur_ov  = sel8 ? ov8 : ov4;
    cur_rdy = sel8 ? rdy8 : rdy4;
    cur_err = sel8 ? err8 : err4;
    cur_res = sel8 ? res8 : {4'h0, res4};
  end

  task automatic drive(input logic v, input logic op, input logic [7:0] a, input logic [7:0] b);
    if (sel8) begin
      v8 = v; op8 = op; a8 = a; b8 = b;
    end else begin
      v4 = v; op4 = op; a4 = a[3:0]; b4 = b[3:0];
    end
  endtask

  task automatic set_ordy(input logic r);
    if (sel8) ordy8 = r;
    else ordy4 = r;
  endtask

  task automatic run_op(input bit wide, input logic op, input int unsigned a, input int unsigned b,
                        input int hold, output int unsigned res);
    int unsigned m, poly, exp_res, exp_lat, lat;
    bit          seen;
    sel8    = wide;
    m       = wide ? 8 : 4;
    poly    = wide ? 32'h11B : 32'h13;
    exp_res = (op == GF_OP_INV) ? ref_inv(a, m, poly) : ref_mul(a, b, m, poly);
    exp_lat = (op == GF_OP_INV) ? 2 * m * (m - 1) : m;
    res     = 0;
    check("idle_in_ready", cur_rdy, 1);
    drive(1'b1, op, 8'(a), 8'(b));
    @(posedge clk);
    #1;
    // Inputs after acceptance must not matter.
    drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
    lat  = 0;
    seen = 0;
    while (!seen && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (cur_ov === 1'b1) seen = 1;
    end
    if (!seen) lat = 9999;
    check("latency", lat, exp_lat);
    if (!seen) return;
    check("result", cur_res, exp_res);
    check("err", cur_err, (op == GF_OP_INV) && (a == 0));
    res = cur_res;
    for (int i = 0; i < hold; i++) begin
      drive(1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
      @(posedge clk);
      #1;
      check("hold_result", cur_res, exp_res);
      check("hold_valid", cur_ov, 1);
      check("hold_in_ready", cur_rdy, 0);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    set_ordy(1'b1);
    @(posedge clk);
    #1;
    set_ordy(1'b0);
    check("post_out_valid", cur_ov, 0);
    check("post_in_ready", cur_rdy, 1);
  endtask

  int unsigned res, a_r, b_r, ones;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy4", rdy4, 1);
    check("rst_ov4", ov4, 0);
    check("rst_res4", res4, 0);
    check("rst_err4", err4, 0);
    check("rst_rdy8", rdy8, 1);
    check("rst_ov8", ov8, 0);
    check("rst_res8", res8, 0);
    check("rst_err8", err8, 0);
    rst = 0;
    @(posedge clk);
    #1;

    // Directed cases with hand-known answers.
    run_op(0, GF_OP_MUL, 3, 7, 0, res);
    check("mul_3_7", res, 9);
    run_op(0, GF_OP_MUL, 8, 2, 0, res);
    check("mul_8_2", res, 3);
    run_op(0, GF_OP_INV, 2, 0, 0, res);
    check("inv_2", res, 9);
    run_op(0, GF_OP_INV, 1, 5, 0, res);
    check("inv_1", res, 1);
    run_op(0, GF_OP_INV, 0, 3, 0, res);
    check("inv_0", res, 0);
    run_op(1, GF_OP_MUL, 'h57, 'h83, 0, res);
    check("aes_mul", res, 'hC1);
    run_op(1, GF_OP_INV, 'h53, 0, 0, res);
    check("aes_inv", res, 'hCA);

    // Backpressure with ignored requests.
    run_op(0, GF_OP_MUL, $urandom_range(15), $urandom_range(15), 10, res);

    // Reset in the middle of an inversion.
    sel8 = 0;
    drive(1'b1, GF_OP_INV, 8'($urandom_range(15, 1)), 8'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h0, 8'h0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    check("midrst_ov", ov4, 0);
    check("midrst_rdy", rdy4, 1);
    ones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (ov4 !== 1'b0) ones++;
    end
    check("midrst_no_result", ones, 0);
    run_op(0, GF_OP_MUL, $urandom_range(15), $urandom_range(15), 0, res);

    // Exhaustive M=4 multiply and inverse.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(0, GF_OP_MUL, i, j, 0, res);
      end
    end
    for (int i = 1; i < 16; i++) begin
      run_op(0, GF_OP_INV, i, $urandom_range(15), 0, res);
      check("a_times_inv", ref_mul(i, res, 4, 'h13), 1);
    end

    // Random mix on both instances with random backpressure.
    repeat (40) begin
      sel8 = 1'($urandom);
      a_r  = sel8 ? $urandom_range(255) : $urandom_range(15);
      b_r  = sel8 ? $urandom_range(255) : $urandom_range(15);
      run_op(sel8, 1'($urandom_range(3) == 0), a_r, b_r, $urandom_range(3), res);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
